// File: rtl/cisc_pkg.sv
// Shared encodings for the CPU-side IO responder: bus commands, register
// offsets, STATUS/CTRL bit positions and the STATUS packing helper.
package cisc_pkg;

  typedef enum logic [1:0] {
    MCMD_IDLE  = 2'b00,
    MCMD_READ  = 2'b01,
    MCMD_WRITE = 2'b10,
    MCMD_RSVD  = 2'b11
  } mcmd_e;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_COUNT  = 2'd3
  } reg_off_e;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_TX_OVF   = 5;

  localparam int CTRL_CLR_BIT   = 0;
  localparam int CTRL_RX_EN_BIT = 1;

  function automatic logic [7:0] pack_status(
    input logic tx_ovf,
    input logic rx_ovr,
    input logic rx_full,
    input logic rx_empty,
    input logic tx_empty,
    input logic tx_full
  );
    logic [7:0] v;
    v              = 8'h00;
    v[ST_TX_OVF]   = tx_ovf;
    v[ST_RX_OVR]   = rx_ovr;
    v[ST_RX_FULL]  = rx_full;
    v[ST_RX_EMPTY] = rx_empty;
    v[ST_TX_EMPTY] = tx_empty;
    v[ST_TX_FULL]  = tx_full;
    return v;
  endfunction

endpackage

// File: rtl/io_responder_byte_fifo.sv
// Byte-wide FIFO with registered count; the head is read combinationally
// from storage so the consumer sees it in the same cycle it becomes valid.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign full  = (r_count == 4'(DEPTH));
  assign empty = (r_count == 4'd0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= 4'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped 4-register window bridging a CPU bus to a transmit and a
// receive byte FIFO, with sticky overflow flags and a receive enable.
module io_responder
  import cisc_pkg::*;
#(
  parameter logic [7:0] BASE  = 8'hF0,
  parameter int         DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] eab,
  input  logic [7:0] edb,
  input  logic [1:0] mcmd,
  output logic [7:0] dout,
  output logic       hit,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid
);

  reg_off_e   w_off;
  logic       w_hit;
  logic       w_rd;
  logic       w_wr;
  logic       w_ctrl_wr;
  logic       w_tx_push;
  logic       w_tx_pop;
  logic       w_rx_push;
  logic       w_rx_pop;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [3:0] w_tx_count;
  logic [3:0] w_rx_count;
  logic [7:0] w_rx_head;
  logic [7:0] w_status;
  logic [7:0] w_rd_mux;
  logic       w_tx_ovf_set;
  logic       w_rx_ovr_set;

  logic [7:0] r_dout;
  logic       r_tx_ovf;
  logic       r_rx_ovr;
  logic       r_rx_en;

  assign w_off = reg_off_e'(eab[1:0]);
  assign w_hit = (eab[7:2] == BASE[7:2]) &&
                 ((mcmd == MCMD_READ) || (mcmd == MCMD_WRITE));
  assign w_rd  = w_hit && (mcmd == MCMD_READ);
  assign w_wr  = w_hit && (mcmd == MCMD_WRITE);

  assign w_ctrl_wr = w_wr && (w_off == REG_CTRL);
  assign w_tx_push = w_wr && (w_off == REG_DATA);
  assign w_tx_pop  = !w_tx_empty && tx_ready;
  assign w_rx_push = rx_valid && r_rx_en;
  assign w_rx_pop  = w_rd && (w_off == REG_DATA) && !w_rx_empty;

  assign w_tx_ovf_set = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_rx_ovr_set = w_rx_push && w_rx_full && !w_rx_pop;

  assign w_status = pack_status(r_tx_ovf, r_rx_ovr, w_rx_full,
                                w_rx_empty, w_tx_empty, w_tx_full);

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (edb),
    .head  (tx_data),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (rx_data),
    .head  (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

  // Read-data selection; an empty RX returns zero rather than stale storage.
  always_comb begin
    w_rd_mux = 8'h00;
    case (w_off)
      REG_DATA: begin
        if (w_rx_empty) w_rd_mux = 8'h00;
        else            w_rd_mux = w_rx_head;
      end
      REG_STATUS: w_rd_mux = w_status;
      REG_CTRL:   w_rd_mux = {6'b000000, r_rx_en, 1'b0};
      REG_COUNT:  w_rd_mux = {w_rx_count, w_tx_count};
      default:    w_rd_mux = 8'h00;
    endcase
  end

  // Sticky flags (a set on the same edge as a clear wins), rx enable and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovr <= 1'b0;
      r_rx_en  <= 1'b1;
      r_dout   <= 8'h00;
    end else begin
      if (w_tx_ovf_set)                         r_tx_ovf <= 1'b1;
      else if (w_ctrl_wr && edb[CTRL_CLR_BIT])  r_tx_ovf <= 1'b0;
      else                                      r_tx_ovf <= r_tx_ovf;
      if (w_rx_ovr_set)                         r_rx_ovr <= 1'b1;
      else if (w_ctrl_wr && edb[CTRL_CLR_BIT])  r_rx_ovr <= 1'b0;
      else                                      r_rx_ovr <= r_rx_ovr;
      if (w_ctrl_wr) r_rx_en <= edb[CTRL_RX_EN_BIT];
      else           r_rx_en <= r_rx_en;
      if (w_rd) r_dout <= w_rd_mux;
      else      r_dout <= r_dout;
    end
  end

  assign hit      = w_hit;
  assign dout     = r_dout;
  assign tx_valid = !w_tx_empty;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: bus reads push their expected data
// into a scoreboard queue that each scenario pops and compares inline.
module tb_io_responder;

  logic       clk;
  logic       reset;
  logic [7:0] eab;
  logic [7:0] edb;
  logic [1:0] mcmd;
  logic [7:0] dout;
  logic       hit;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic [7:0] exp_q [$];
  logic [7:0] e;
  int         n_vec = 0;
  int         n_err = 0;

  io_responder #(.BASE(8'hF0), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .eab      (eab),
    .edb      (edb),
    .mcmd     (mcmd),
    .dout     (dout),
    .hit      (hit),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All drivers start and end one time unit after a rising edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    eab = a; edb = d; mcmd = 2'b10;
    @(posedge clk); #1;
    mcmd = 2'b00;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] expv);
    exp_q.push_back(expv);
    eab = a; mcmd = 2'b01;
    @(posedge clk); #1;
    mcmd = 2'b00;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (dout !== 8'h00) begin n_err++; $display("FAIL rst_dout got=%h exp=00", dout); end
    n_vec++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    eab = 8'hF0; mcmd = 2'b01; #1;
    n_vec++;
    if (hit !== 1'b1) begin n_err++; $display("FAIL rst_hit got=%b exp=1", hit); end
    mcmd = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    bus_read(8'hF1, 8'h06);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rst_status got=%h exp=%h", dout, e); end
    bus_read(8'hF2, 8'h02);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rst_ctrl got=%h exp=%h", dout, e); end
    bus_read(8'hF3, 8'h00);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rst_count got=%h exp=%h", dout, e); end
  endtask

  task automatic test_tx_basic;
    tx_ready = 1'b0;
    bus_write(8'hF0, 8'hA5);
    n_vec++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      n_err++; $display("FAIL tx_head got=%b/%h exp=1/a5", tx_valid, tx_data);
    end
    bus_read(8'hF1, 8'h04);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL tx_status got=%h exp=%h", dout, e); end
    bus_read(8'hF3, 8'h01);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL tx_count got=%h exp=%h", dout, e); end
    // dout must hold across idle cycles
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (dout !== 8'h01) begin n_err++; $display("FAIL dout_hold got=%h exp=01", dout); end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    n_vec++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drain1 got=%b exp=0", tx_valid); end
  endtask

  task automatic test_tx_overflow;
    logic [7:0] b;
    b = 8'h11;
    for (int i = 0; i < 5; i++) begin
      bus_write(8'hF0, b);
      b = b + 8'h01;
    end
    bus_read(8'hF1, 8'h25);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL ovf_status got=%h exp=%h", dout, e); end
    bus_read(8'hF3, 8'h04);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL ovf_count got=%h exp=%h", dout, e); end
    tx_ready = 1'b1;
    b = 8'h11;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== b) begin
        n_err++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", tx_valid, tx_data, b);
      end
      @(posedge clk); #1;
      b = b + 8'h01;
    end
    tx_ready = 1'b0;
    n_vec++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got=%b exp=0", tx_valid); end
    bus_write(8'hF2, 8'h03);
    bus_read(8'hF1, 8'h06);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL ovf_clear got=%h exp=%h", dout, e); end
  endtask

  task automatic test_rx;
    rx_push(8'h3C);
    bus_read(8'hF0, 8'h3C);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rx_data got=%h exp=%h", dout, e); end
    bus_read(8'hF0, 8'h00);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rx_empty_rd got=%h exp=%h", dout, e); end
    bus_read(8'hF3, 8'h00);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rx_count got=%h exp=%h", dout, e); end
  endtask

  task automatic test_rx_full;
    for (int i = 0; i < 4; i++) rx_push(8'h41 + 8'(i));
    bus_read(8'hF1, 8'h0A);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_status got=%h exp=%h", dout, e); end
    // pop and push on the same edge while full
    exp_q.push_back(8'h41);
    eab = 8'hF0; mcmd = 2'b01; rx_data = 8'h77; rx_valid = 1'b1;
    @(posedge clk); #1;
    mcmd = 2'b00; rx_valid = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_poppush got=%h exp=%h", dout, e); end
    bus_read(8'hF1, 8'h0A);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_no_ovr got=%h exp=%h", dout, e); end
    // overrun set on the same edge as a clear: set wins
    eab = 8'hF2; edb = 8'h03; mcmd = 2'b10; rx_data = 8'hEE; rx_valid = 1'b1;
    @(posedge clk); #1;
    mcmd = 2'b00; rx_valid = 1'b0;
    bus_read(8'hF1, 8'h1A);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_setwins got=%h exp=%h", dout, e); end
    bus_write(8'hF2, 8'h03);
    bus_read(8'hF1, 8'h0A);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_clr got=%h exp=%h", dout, e); end
    bus_read(8'hF0, 8'h42);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_rd2 got=%h exp=%h", dout, e); end
    bus_read(8'hF0, 8'h43);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_rd3 got=%h exp=%h", dout, e); end
    bus_read(8'hF0, 8'h44);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_rd4 got=%h exp=%h", dout, e); end
    bus_read(8'hF0, 8'h77);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxf_rd_last got=%h exp=%h", dout, e); end
  endtask

  task automatic test_rx_disable;
    bus_write(8'hF2, 8'h00);
    bus_read(8'hF2, 8'h00);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxen_off got=%h exp=%h", dout, e); end
    rx_push(8'h55);
    bus_read(8'hF3, 8'h00);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxen_ignored got=%h exp=%h", dout, e); end
    bus_write(8'hF2, 8'h02);
    bus_read(8'hF2, 8'h02);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rxen_on got=%h exp=%h", dout, e); end
  endtask

  task automatic test_nonhit;
    eab = 8'hEF; edb = 8'hC1; mcmd = 2'b10; #1;
    n_vec++;
    if (hit !== 1'b0) begin n_err++; $display("FAIL nh_ef got=%b exp=0", hit); end
    @(posedge clk); #1;
    eab = 8'hF4; #1;
    n_vec++;
    if (hit !== 1'b0) begin n_err++; $display("FAIL nh_f4 got=%b exp=0", hit); end
    @(posedge clk); #1;
    eab = 8'hF0; mcmd = 2'b11; #1;
    n_vec++;
    if (hit !== 1'b0) begin n_err++; $display("FAIL nh_cmd11 got=%b exp=0", hit); end
    @(posedge clk); #1;
    mcmd = 2'b00;
    n_vec++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL nh_tx got=%b exp=0", tx_valid); end
    bus_read(8'hF3, 8'h00);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL nh_count got=%h exp=%h", dout, e); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(8'hF0, 8'hA0 + 8'(i));
    // write into a full TX while the head is leaving
    tx_ready = 1'b1;
    bus_write(8'hF0, 8'h99);
    tx_ready = 1'b0;
    bus_read(8'hF1, 8'h05);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL b2b_status got=%h exp=%h", dout, e); end
    bus_read(8'hF3, 8'h04);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL b2b_count got=%h exp=%h", dout, e); end
    tx_ready = 1'b1;
    b = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== b) begin
        n_err++; $display("FAIL b2b_drain got=%b/%h exp=1/%h", tx_valid, tx_data, b);
      end
      @(posedge clk); #1;
      b = (i == 2) ? 8'h99 : b + 8'h01;
    end
    tx_ready = 1'b0;
    n_vec++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_reset_mid;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(8'hF0, 8'hB0 + 8'(i));
    for (int i = 0; i < 3; i++) rx_push(8'hC0 + 8'(i));
    bus_read(8'hF3, 8'h33);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rm_count got=%h exp=%h", dout, e); end
    tx_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rm_tx_valid got=%b exp=0", tx_valid); end
    n_vec++;
    if (dout !== 8'h00) begin n_err++; $display("FAIL rm_dout got=%h exp=00", dout); end
    tx_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus_read(8'hF1, 8'h06);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rm_status got=%h exp=%h", dout, e); end
    bus_read(8'hF3, 8'h00);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rm_count0 got=%h exp=%h", dout, e); end
  endtask

  initial begin
    reset = 1'b0; eab = 8'h00; edb = 8'h00; mcmd = 2'b00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    test_reset;
    test_tx_basic;
    test_tx_overflow;
    test_rx;
    test_rx_full;
    test_rx_disable;
    test_nonhit;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
